// File: rtl/adder_seq_pkg.sv
// Shared types and defaults for the adder measurement sequencer.
package adder_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSettle,
    StRun,
    StCapture,
    StResult
  } seq_state_e;

  localparam int unsigned DefWidth   = 32;
  localparam int unsigned DefWinW    = 16;
  localparam int unsigned DefSettle  = 2;
  localparam int unsigned DefAvgLog2 = 2;
  localparam int unsigned SettleMin  = 1;

endpackage

// File: rtl/adder_seq_window_timer.sv
// Loadable down-counter; done_o flags the last counted cycle of a loaded interval.
module adder_seq_window_timer #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] value_i,
  input  logic            start_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (start_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = start_i && (cnt_q == CntW'(1));

endmodule

// File: rtl/adder_measurement_sequencer.sv
// Command-driven measurement sequencer for the instrumented adder.
// Optional multi-pass accumulation is enabled by defining ADDER_SEQ_AVG_EN.
module adder_measurement_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned WIN_W    = DefWinW,
  parameter int unsigned SETTLE   = DefSettle,
  parameter int unsigned AVG_LOG2 = DefAvgLog2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [WIN_W-1:0] cmd_window,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_run,
  output logic             adder_clear,
  input  logic [WIDTH-1:0] adder_count,
  input  logic [WIDTH-1:0] adder_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_count,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_sum_ok,
  output logic             busy
);

`ifdef ADDER_SEQ_AVG_EN
  localparam int unsigned AvgEn = 1;
`else
  localparam int unsigned AvgEn = 0;
`endif
  localparam int unsigned PassW     = AVG_LOG2 * AvgEn + 1;
  localparam int unsigned Passes    = 1 << (AVG_LOG2 * AvgEn);
  localparam int unsigned SettleEff = (SETTLE < SettleMin) ? SettleMin : SETTLE;

  seq_state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIDTH-1:0] res_count_q, res_count_d, res_sum_q, res_sum_d;
  logic             res_sum_ok_q, res_sum_ok_d;
  logic [PassW-1:0] pass_q, pass_d;

  logic             accept, last_pass, sum_match;
  logic [WIDTH-1:0] exp_sum;
  logic             tmr_load, tmr_start, tmr_done;
  logic [WIN_W-1:0] tmr_value;

  assign accept    = cmd_valid && (state_q == StIdle);
  assign last_pass = (pass_q == PassW'(Passes - 1));
  // Carry-out dropped: the reference is the sum modulo 2^WIDTH.
  assign exp_sum   = a_q + b_q;
  assign sum_match = (adder_sum == exp_sum);

  adder_seq_window_timer #(
    .CntW(WIN_W)
  ) u_timer (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .load_i (tmr_load),
    .value_i(tmr_value),
    .start_i(tmr_start),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    tmr_load    = 1'b0;
    tmr_start   = 1'b0;
    tmr_value   = '0;
    cmd_ready   = 1'b0;
    adder_clear = 1'b0;
    adder_run   = 1'b0;
    res_valid   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = StClear;
      end
      StClear: begin
        adder_clear = 1'b1;
        tmr_load    = 1'b1;
        tmr_value   = WIN_W'(SettleEff);
        state_d     = StSettle;
      end
      StSettle: begin
        tmr_start = 1'b1;
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = win_q;
          state_d   = StRun;
        end
      end
      StRun: begin
        adder_run = 1'b1;
        tmr_start = 1'b1;
        if (tmr_done) state_d = StCapture;
      end
      StCapture: begin
        // Further passes restart at CLEAR with no idle cycle in between.
        state_d = last_pass ? StResult : StClear;
      end
      StResult: begin
        res_valid = 1'b1;
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef ADDER_SEQ_AVG_EN
  logic [WIDTH:0]   acc_wide;
  logic [WIDTH-1:0] acc_sat;
  assign acc_wide = {1'b0, res_count_q} + {1'b0, adder_count};
  assign acc_sat  = acc_wide[WIDTH] ? '1 : acc_wide[WIDTH-1:0];
`endif

  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    win_d        = win_q;
    res_count_d  = res_count_q;
    res_sum_d    = res_sum_q;
    res_sum_ok_d = res_sum_ok_q;
    pass_d       = pass_q;
    if (accept) begin
      a_d    = cmd_a;
      b_d    = cmd_b;
      win_d  = (cmd_window == '0) ? WIN_W'(1) : cmd_window;
      pass_d = '0;
`ifdef ADDER_SEQ_AVG_EN
      res_count_d  = '0;
      res_sum_ok_d = 1'b1;
`endif
    end
    if (state_q == StCapture) begin
      res_sum_d = adder_sum;
      pass_d    = pass_q + PassW'(1);
`ifdef ADDER_SEQ_AVG_EN
      res_count_d  = acc_sat;
      res_sum_ok_d = res_sum_ok_q & sum_match;
`else
      res_count_d  = adder_count;
      res_sum_ok_d = sum_match;
`endif
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      win_q        <= '0;
      res_count_q  <= '0;
      res_sum_q    <= '0;
      res_sum_ok_q <= 1'b0;
      pass_q       <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      win_q        <= win_d;
      res_count_q  <= res_count_d;
      res_sum_q    <= res_sum_d;
      res_sum_ok_q <= res_sum_ok_d;
      pass_q       <= pass_d;
    end
  end

  assign adder_a    = a_q;
  assign adder_b    = b_q;
  assign res_count  = res_count_q;
  assign res_sum    = res_sum_q;
  assign res_sum_ok = res_sum_ok_q;
  assign busy       = (state_q != StIdle);

endmodule
